regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_pkg.sv | 11 +
 rtl/rf_wr_fifo.sv | 70 +++++++
 rtl/regfile_write_arbiter.sv | 92 +++++++++
 tb/tb_regfile_write_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file write types: address/data widths and the write-request record.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// Deferred-write FIFO for long-latency results. A winning writeback can kill
// queued entries by address; killed entries stay in place until popped.
module rf_wr_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    push_i,
  input  logic [REG_ADDR_W-1:0]   push_addr_i,
  input  logic [DATA_W-1:0]       push_data_i,
  input  logic                    pop_i,
  input  logic                    inval_i,
  input  logic [REG_ADDR_W-1:0]   inval_addr_i,
  input  logic [REG_ADDR_W-1:0]   rs_addr_i,
  input  logic [REG_ADDR_W-1:0]   rt_addr_i,
  output logic [$clog2(DEPTH):0]  count_o,
  output wr_req_t                 head_o,
  output logic                    hit_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]                 vld_q;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0]     data_q;
  logic [PW-1:0]                    rd_ptr, wr_ptr;
  logic [CW-1:0]                    count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      vld_q   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      // Kill, then pop, then push: the push slot is always free, so order only
      // matters between kill and pop on the head, which both clear.
      for (int i = 0; i < DEPTH; i++)
        if (inval_i && addr_q[i] == inval_addr_i) vld_q[i] <= 1'b0;
      if (pop_i) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      if (push_i) begin
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      addr_q[wr_ptr] <= push_addr_i;
      data_q[wr_ptr] <= push_data_i;
    end
  end

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && addr_q[i] != '0 && (addr_q[i] == rs_addr_i || addr_q[i] == rt_addr_i))
        hit_o = 1'b1;
  end

  assign count_o = count_q;
  assign head_o  = '{valid: vld_q[rd_ptr], addr: addr_q[rd_ptr], data: data_q[rd_ptr]};
endmodule

// File: rtl/regfile_write_arbiter.sv
// Single-port register-file write arbiter: pipeline writeback vs. long-latency
// results, with a deferred FIFO, starvation forcing, WAW kill and decode hazard.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  output logic                  wb_stall_o,
  input  logic                  mu_valid_i,
  input  logic [REG_ADDR_W-1:0] mu_addr_i,
  input  logic [DATA_W-1:0]     mu_data_i,
  output logic                  mu_ready_o,
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_i,
  output logic                  hazard_o,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0]     rf_data_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] count;
  wr_req_t       head, grant_d;
  logic          fifo_hit, fifo_empty, head_live, head_dead;
  logic          force_pop, wb_grant, mu_acc, mu_live, bypass, push, pop_live, pop;
  logic [SW-1:0] starve_q;

  always_comb begin
    fifo_empty = (count == '0);
    head_live  = !fifo_empty && head.valid;
    head_dead  = !fifo_empty && !head.valid;
    force_pop  = rst_n_i && head_live && (starve_q == SW'(STARVE_LIMIT));
    wb_stall_o = force_pop;
    mu_ready_o = rst_n_i && (count < CW'(DEPTH));
    wb_grant   = wb_valid_i && !force_pop && (wb_addr_i != '0);
    mu_acc     = mu_valid_i && mu_ready_o;
    // An mu result racing a granted wb to the same register is already stale.
    mu_live    = mu_acc && (mu_addr_i != '0) && !(wb_grant && mu_addr_i == wb_addr_i);
    pop_live   = head_live && (force_pop || !wb_grant);
    bypass     = mu_live && fifo_empty && !wb_grant;
    push       = mu_live && !bypass;
    pop        = pop_live || head_dead;
    grant_d    = '0;
    if (pop_live)      grant_d = head;
    else if (wb_grant) grant_d = '{valid: 1'b1, addr: wb_addr_i, data: wb_data_i};
    else if (bypass)   grant_d = '{valid: 1'b1, addr: mu_addr_i, data: mu_data_i};
  end

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .push_i       (push),
    .push_addr_i  (mu_addr_i),
    .push_data_i  (mu_data_i),
    .pop_i        (pop),
    .inval_i      (wb_grant),
    .inval_addr_i (wb_addr_i),
    .rs_addr_i    (rs_addr_i),
    .rt_addr_i    (rt_addr_i),
    .count_o      (count),
    .head_o       (head),
    .hit_o        (fifo_hit)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                 starve_q <= '0;
    else if (fifo_empty || pop)   starve_q <= '0;
    else if (head_live && wb_grant) starve_q <= starve_q + SW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rf_we_o   <= 1'b0;
      rf_addr_o <= '0;
      rf_data_o <= '0;
    end else begin
      rf_we_o   <= grant_d.valid;
      rf_addr_o <= grant_d.addr;
      rf_data_o <= grant_d.data;
    end
  end

  assign hazard_o = fifo_hit ||
                    (rf_we_o && rf_addr_o != '0 && (rf_addr_o == rs_addr_i || rf_addr_o == rt_addr_i));
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        wb_valid_i, mu_valid_i;
  logic [4:0]  wb_addr_i, mu_addr_i, rs_addr_i, rt_addr_i;
  logic [31:0] wb_data_i, mu_data_i;
  logic        wb_stall_o, mu_ready_o, hazard_o, rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  regfile_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_stall_o(wb_stall_o),
    .mu_valid_i(mu_valid_i), .mu_addr_i(mu_addr_i), .mu_data_i(mu_data_i), .mu_ready_o(mu_ready_o),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .hazard_o(hazard_o),
    .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wb_valid_i = 0; wb_addr_i = 0; wb_data_i = 0;
    mu_valid_i = 0; mu_addr_i = 0; mu_data_i = 0;
    rs_addr_i  = 0; rt_addr_i = 0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_valid_i = 1; wb_addr_i = a; wb_data_i = d;
  endtask

  task automatic mu(input logic [4:0] a, input logic [31:0] d);
    mu_valid_i = 1; mu_addr_i = a; mu_data_i = d;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"}, rf_we_o, we);
    if (we) begin
      chk({tag, ".addr"}, rf_addr_o, a);
      chk({tag, ".data"}, rf_data_o, d);
    end
  endtask

  initial begin
    rst_n_i = 0;
    idle();
    tick(); tick();
    chk_rf("rst", 0, 0, 0);
    chk("rst.addr", rf_addr_o, 0);
    chk("rst.data", rf_data_o, 0);
    chk("rst.ready", mu_ready_o, 0);
    chk("rst.stall", wb_stall_o, 0);
    rst_n_i = 1;
    #1 chk("rel.ready", mu_ready_o, 1);

    // idle mu bypass
    mu(3, 32'hAA);
    tick();
    idle(); rs_addr_i = 3;
    chk_rf("bypass", 1, 3, 32'hAA);
    #1 chk("bypass.hazard", hazard_o, 1);
    tick();
    chk_rf("bypass.after", 0, 0, 0);

    // wb and mu together: wb first, mu queued
    wb(5, 32'h55); mu(6, 32'h66);
    tick();
    idle(); rs_addr_i = 6;
    chk_rf("both.wb", 1, 5, 32'h55);
    #1 chk("both.hazard", hazard_o, 1);
    tick();
    chk_rf("both.mu", 1, 6, 32'h66);
    idle();
    tick();
    rs_addr_i = 6;
    chk_rf("both.after", 0, 0, 0);
    #1 chk("both.nohaz", hazard_o, 0);

    // WAW: queued mu 7 killed by later wb 7
    wb(9, 32'h99); mu(7, 32'h77);
    tick();
    idle(); rt_addr_i = 7;
    chk_rf("waw.wb9", 1, 9, 32'h99);
    #1 chk("waw.qhaz", hazard_o, 1);
    wb(7, 32'h1);
    tick();
    idle();
    chk_rf("waw.wb7", 1, 7, 32'h1);
    tick();
    chk_rf("waw.dead", 0, 0, 0);
    tick();
    chk_rf("waw.none", 0, 0, 0);

    // starvation: continuous wb 10, mu 11/12/13 held until accepted
    for (int c = 0; c <= 10; c++) begin
      wb(10, 32'h100 + c);
      if (c == 0) mu(11, 32'hB1);
      else if (c == 1) mu(12, 32'hB2);
      else mu(13, 32'hB3);
      #1;
      chk($sformatf("starve.ready%0d", c), mu_ready_o, (c < 2 || c == 10));
      chk($sformatf("starve.stall%0d", c), wb_stall_o, (c == 9));
      tick();
      if (c == 9) chk_rf("starve.force", 1, 11, 32'hB1);
      else        chk_rf($sformatf("starve.wb%0d", c), 1, 10, 32'h100 + c);
    end
    idle();
    tick();
    chk_rf("starve.h12", 1, 12, 32'hB2);
    tick();
    chk_rf("starve.h13", 1, 13, 32'hB3);
    tick();
    chk_rf("starve.done", 0, 0, 0);

    // address 0 requests are dropped
    wb(0, 32'h5);
    tick();
    idle();
    chk_rf("zero.wb", 0, 0, 0);
    mu(0, 32'h6);
    #1 chk("zero.ready", mu_ready_o, 1);
    tick();
    idle();
    chk_rf("zero.mu", 0, 0, 0);
    tick();
    chk_rf("zero.after", 0, 0, 0);

    // reset with two queued entries
    wb(20, 32'h20); mu(21, 32'h21);
    tick();
    wb(22, 32'h22); mu(23, 32'h23);
    tick();
    chk_rf("rq.wb22", 1, 22, 32'h22);
    idle();
    rst_n_i = 0;
    #1;
    chk("rq.ready", mu_ready_o, 0);
    chk("rq.stall", wb_stall_o, 0);
    tick();
    chk_rf("rq.rst0", 0, 0, 0);
    tick();
    chk_rf("rq.rst1", 0, 0, 0);
    rst_n_i = 1;
    rs_addr_i = 21; rt_addr_i = 23;
    #1;
    chk("rq.rel_ready", mu_ready_o, 1);
    chk("rq.nohaz", hazard_o, 0);
    tick();
    chk_rf("rq.post0", 0, 0, 0);
    tick();
    chk_rf("rq.post1", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
